// File: rtl/pc_sequencer.sv
// Program counter sequencer: selects the next PC (sequential, branch or jump)
// and issues instruction fetches over a valid/ready handshake.
module pc_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               STEP     = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             stall,
    input  logic             halt,
    output logic             halted,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pending_target_reg;
    logic             pending_valid_reg;
    logic             fetch_valid_reg;
    logic             halted_reg;
    logic             misalign_err_reg;

    logic             redirect_en;
    logic [WIDTH-1:0] redirect_raw;
    logic [WIDTH-1:0] redirect_target;
    logic             redirect_misaligned;

    // Jump wins over branch when both are asserted in the same cycle.
    assign redirect_en         = jump_en | branch_en;
    assign redirect_raw        = jump_en ? jump_target : branch_target;
    assign redirect_misaligned = redirect_en & (redirect_raw[1:0] != 2'b00);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_align
            if (gi < 2) begin : g_low
                assign redirect_target[gi] = 1'b0;
            end else begin : g_high
                assign redirect_target[gi] = redirect_raw[gi];
            end
        end
    endgenerate

    assign pc_next_seq  = pc_reg + STEP_W;
    assign pc           = pc_reg;
    assign fetch_valid  = fetch_valid_reg;
    assign halted       = halted_reg;
    assign misalign_err = misalign_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            pc_reg             <= RESET_PC;
            pending_target_reg <= '0;
            pending_valid_reg  <= 1'b0;
            fetch_valid_reg    <= 1'b0;
            halted_reg         <= 1'b0;
            misalign_err_reg   <= 1'b0;
        end else begin
            if ((state_reg != ST_HALTED) && redirect_misaligned) begin
                misalign_err_reg <= 1'b1;
            end

            unique case (state_reg)
                ST_IDLE: begin
                    if (halt) begin
                        state_reg       <= ST_HALTED;
                        fetch_valid_reg <= 1'b0;
                        halted_reg      <= 1'b1;
                        if (redirect_en) begin
                            pending_valid_reg  <= 1'b1;
                            pending_target_reg <= redirect_target;
                        end
                    end else if (!stall) begin
                        // A redirect seen on the issue edge is newer than any pending one.
                        state_reg         <= ST_REQ;
                        fetch_valid_reg   <= 1'b1;
                        pending_valid_reg <= 1'b0;
                        if (redirect_en) begin
                            pc_reg <= redirect_target;
                        end else if (pending_valid_reg) begin
                            pc_reg <= pending_target_reg;
                        end
                    end else if (redirect_en) begin
                        pending_valid_reg  <= 1'b1;
                        pending_target_reg <= redirect_target;
                    end
                end

                ST_REQ: begin
                    if (fetch_ready) begin
                        if (redirect_en) begin
                            pc_reg <= redirect_target;
                        end else if (pending_valid_reg) begin
                            pc_reg <= pending_target_reg;
                        end else begin
                            pc_reg <= pc_next_seq;
                        end
                        pending_valid_reg <= 1'b0;

                        if (halt) begin
                            state_reg       <= ST_HALTED;
                            fetch_valid_reg <= 1'b0;
                            halted_reg      <= 1'b1;
                        end else if (stall) begin
                            state_reg       <= ST_IDLE;
                            fetch_valid_reg <= 1'b0;
                        end
                    end else if (redirect_en) begin
                        // Request must stay stable; remember the redirect for later.
                        pending_valid_reg  <= 1'b1;
                        pending_target_reg <= redirect_target;
                    end
                end

                ST_HALTED: begin
                    fetch_valid_reg <= 1'b0;
                    halted_reg      <= 1'b1;
                end

                default: begin
                    state_reg       <= ST_IDLE;
                    fetch_valid_reg <= 1'b0;
                    halted_reg      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: accepted fetch addresses are logged by a
// monitor and compared against an expected-PC queue; state outputs checked inline.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic        fetch_ready, branch_en, jump_en, stall, halt;
    logic [31:0] branch_target, jump_target;

    logic        fetch_valid, halted, misalign_err;
    logic [31:0] pc, pc_next_seq;
    logic        fetch_valid2, halted2, misalign_err2;
    logic [31:0] pc2, pc_next_seq2;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] acc_pc [0:63];
    int          acc_cnt = 0;
    int          rd_ptr = 0;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000), .STEP(4)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .pc(pc), .pc_next_seq(pc_next_seq),
        .branch_en(branch_en), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target),
        .stall(stall), .halt(halt),
        .halted(halted), .misalign_err(misalign_err)
    );

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .STEP(4)) dut_wrap (
        .clk(clk), .rst(rst2),
        .fetch_valid(fetch_valid2), .fetch_ready(fetch_ready),
        .pc(pc2), .pc_next_seq(pc_next_seq2),
        .branch_en(branch_en), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target),
        .stall(stall), .halt(halt),
        .halted(halted2), .misalign_err(misalign_err2)
    );

    // Inputs change 1 time unit after posedge, so at negedge they are the
    // values the next posedge will sample.
    always @(negedge clk) begin
        if (!rst && fetch_valid && fetch_ready && acc_cnt < 64) begin
            acc_pc[acc_cnt] <= pc;
            acc_cnt         <= acc_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        fetch_ready = 1'b1; branch_en = 1'b0; jump_en = 1'b0;
        branch_target = '0; jump_target = '0; stall = 1'b0; halt = 1'b0;
        tick(2);
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", fetch_valid); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b expected 0", halted); end
        vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
        rst = 1'b0;
        tick(1);
        vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid: got %b expected 1", fetch_valid); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL first_pc: got %h expected %h", pc, 32'h0); end
    endtask

    task automatic test_sequential();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        tick(2);
        vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL seq_pc: got %h expected %h", pc, 32'h8); end
        vectors++; if (pc_next_seq !== 32'hC) begin miscompares++; $display("FAIL seq_next: got %h expected %h", pc_next_seq, 32'hC); end
        while (exp_q.size() > 0) begin
            exp_pc = exp_q.pop_front();
            vectors++;
            if (rd_ptr >= acc_cnt) begin
                miscompares++; $display("FAIL seq_accept_missing: got none expected %h", exp_pc);
            end else begin
                $display("accept %0d pc=%h expected=%h", rd_ptr, acc_pc[rd_ptr], exp_pc);
                if (acc_pc[rd_ptr] !== exp_pc) begin miscompares++; $display("FAIL seq_accept: got %h expected %h", acc_pc[rd_ptr], exp_pc); end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_wait_branch();
        fetch_ready = 1'b0; branch_en = 1'b1; branch_target = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL wait_pc[%0d]: got %h expected %h", i, pc, 32'h8); end
            vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL wait_valid[%0d]: got %b expected 1", i, fetch_valid); end
        end
        fetch_ready = 1'b1; branch_en = 1'b0;
        exp_q.push_back(32'h8);
        tick(1);
        vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL pending_pc: got %h expected %h", pc, 32'h40); end
    endtask

    task automatic test_jump_priority();
        jump_en = 1'b1; jump_target = 32'h100; branch_en = 1'b1; branch_target = 32'h40;
        exp_q.push_back(32'h40);
        tick(1);
        jump_en = 1'b0; branch_en = 1'b0;
        vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL jump_prio_pc: got %h expected %h", pc, 32'h100); end
        while (exp_q.size() > 0) begin
            exp_pc = exp_q.pop_front();
            vectors++;
            if (rd_ptr >= acc_cnt) begin
                miscompares++; $display("FAIL jump_accept_missing: got none expected %h", exp_pc);
            end else begin
                $display("accept %0d pc=%h expected=%h", rd_ptr, acc_pc[rd_ptr], exp_pc);
                if (acc_pc[rd_ptr] !== exp_pc) begin miscompares++; $display("FAIL jump_accept: got %h expected %h", acc_pc[rd_ptr], exp_pc); end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_misalign();
        branch_en = 1'b1; branch_target = 32'h43;
        exp_q.push_back(32'h100);
        tick(1);
        branch_en = 1'b0;
        vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL misalign_pc: got %h expected %h", pc, 32'h40); end
        vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_set: got %b expected 1", misalign_err); end
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        tick(2);
        vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_sticky: got %b expected 1", misalign_err); end
        vectors++; if (pc !== 32'h48) begin miscompares++; $display("FAIL misalign_seq_pc: got %h expected %h", pc, 32'h48); end
    endtask

    task automatic test_stall_pending();
        stall = 1'b1;
        exp_q.push_back(32'h48);
        tick(1);
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stall_valid: got %b expected 0", fetch_valid); end
        vectors++; if (pc !== 32'h4C) begin miscompares++; $display("FAIL stall_pc: got %h expected %h", pc, 32'h4C); end
        branch_en = 1'b1; branch_target = 32'h200;
        tick(1);
        branch_en = 1'b0;
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL idle_hold_valid: got %b expected 0", fetch_valid); end
        vectors++; if (pc !== 32'h4C) begin miscompares++; $display("FAIL idle_hold_pc: got %h expected %h", pc, 32'h4C); end
        stall = 1'b0;
        tick(1);
        vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL idle_exit_valid: got %b expected 1", fetch_valid); end
        vectors++; if (pc !== 32'h200) begin miscompares++; $display("FAIL idle_exit_pc: got %h expected %h", pc, 32'h200); end
    endtask

    task automatic test_halt();
        fetch_ready = 1'b0; halt = 1'b1;
        tick(2);
        vectors++; if (pc !== 32'h200) begin miscompares++; $display("FAIL halt_wait_pc: got %h expected %h", pc, 32'h200); end
        vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL halt_wait_valid: got %b expected 1", fetch_valid); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_wait_halted: got %b expected 0", halted); end
        fetch_ready = 1'b1;
        exp_q.push_back(32'h200);
        tick(1);
        halt = 1'b0; branch_en = 1'b1; branch_target = 32'h300;
        tick(3);
        branch_en = 1'b0;
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halted_flag: got %b expected 1", halted); end
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL halted_valid: got %b expected 0", fetch_valid); end
        vectors++; if (pc !== 32'h204) begin miscompares++; $display("FAIL halted_pc: got %h expected %h", pc, 32'h204); end
        vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL halted_misalign: got %b expected 1", misalign_err); end
        while (exp_q.size() > 0) begin
            exp_pc = exp_q.pop_front();
            vectors++;
            if (rd_ptr >= acc_cnt) begin
                miscompares++; $display("FAIL halt_accept_missing: got none expected %h", exp_pc);
            end else begin
                $display("accept %0d pc=%h expected=%h", rd_ptr, acc_pc[rd_ptr], exp_pc);
                if (acc_pc[rd_ptr] !== exp_pc) begin miscompares++; $display("FAIL halt_accept: got %h expected %h", acc_pc[rd_ptr], exp_pc); end
                rd_ptr++;
            end
        end
        vectors++; if (acc_cnt !== rd_ptr) begin miscompares++; $display("FAIL accept_count: got %0d expected %0d", acc_cnt, rd_ptr); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rerst_pc: got %h expected %h", pc, 32'h0); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rerst_halted: got %b expected 0", halted); end
        vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL rerst_misalign: got %b expected 0", misalign_err); end
    endtask

    task automatic test_wrap();
        tick(1);
        vectors++; if (pc2 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_reset_pc: got %h expected %h", pc2, 32'hFFFF_FFFC); end
        vectors++; if (fetch_valid2 !== 1'b0) begin miscompares++; $display("FAIL wrap_reset_valid: got %b expected 0", fetch_valid2); end
        vectors++; if (halted2 !== 1'b0 || misalign_err2 !== 1'b0) begin miscompares++; $display("FAIL wrap_reset_flags: got %b%b expected 00", halted2, misalign_err2); end
        rst2 = 1'b0;
        tick(1);
        vectors++; if (fetch_valid2 !== 1'b1) begin miscompares++; $display("FAIL wrap_valid: got %b expected 1", fetch_valid2); end
        vectors++; if (pc2 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_first_pc: got %h expected %h", pc2, 32'hFFFF_FFFC); end
        vectors++; if (pc_next_seq2 !== 32'h0) begin miscompares++; $display("FAIL wrap_next_seq: got %h expected %h", pc_next_seq2, 32'h0); end
        tick(1);
        $display("wrap accept pc=%h", pc2);
        vectors++; if (pc2 !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h expected %h", pc2, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_branch();
        test_jump_priority();
        test_misalign();
        test_stall_pending();
        test_halt();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
